// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- byte-wide instruction-memory read bus.
//   imem_req    : fetch unit -> memory, read request
//   imem_addr   : fetch unit -> memory, 64-bit byte address
//   imem_rvalid : memory -> fetch unit, imem_rdata valid (same cycle or later)
//   imem_rdata  : memory -> fetch unit, returned byte
// master modport = fetch unit side, slave modport = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [7:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- Y86-64 style instruction fetch over a byte-wide memory bus.
// Requests one byte per accepted cycle starting at pc, decodes the opcode,
// register and constant fields, and presents a complete instruction with
// instr_valid_o until a new PC is supplied.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   pc_next_i/_valid_i    : next PC, one-cycle load pulse (honoured in DONE only)
//   imem                  : instruction memory bus (master side)
//   instr_valid_o         : decoded instruction complete
//   icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, pc_o : decoded fields
//   halt_o, instr_err_o   : sticky halt / invalid-icode flags
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [63:0]   pc_next_i,
  input  logic          pc_next_valid_i,
  fetch_unit_if.master  imem,
  output logic          instr_valid_o,
  output logic [3:0]    icode_o,
  output logic [3:0]    ifun_o,
  output logic [3:0]    rA_o,
  output logic [3:0]    rB_o,
  output logic [63:0]   valC_o,
  output logic [63:0]   valP_o,
  output logic [63:0]   pc_o,
  output logic          halt_o,
  output logic          instr_err_o
);

  typedef enum logic [1:0] {S_REQ, S_DONE, S_HALT, S_ERR} state_t;

  localparam logic [3:0] I_HALT = 4'h0;

  state_t      state;
  logic [3:0]  byte_idx;
  logic [3:0]  cur_icode;
  logic [3:0]  len;
  logic        last;
  logic [7:0]  rdata;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
      default:                                  has_reg = 1'b0;
    endcase
  endfunction

  assign rdata = imem.imem_rdata;
  // Byte 0 is decoded straight off the bus so a 1-byte instruction completes
  // on the same edge that captures it.
  assign cur_icode = (byte_idx == 4'd0) ? rdata[7:4] : icode_o;
  assign len       = instr_len(cur_icode);
  assign last      = (byte_idx == len - 4'd1);

  // Request is gated by reset so it stays low while reset is held even though
  // the state already sits in REQ.
  assign imem.imem_req  = rst_n_i && (state == S_REQ);
  assign imem.imem_addr = pc_o + {60'b0, byte_idx};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_REQ;
      pc_o          <= RESET_PC;
      byte_idx      <= '0;
      icode_o       <= '0;
      ifun_o        <= '0;
      rA_o          <= '0;
      rB_o          <= '0;
      valC_o        <= '0;
      valP_o        <= '0;
      instr_valid_o <= 1'b0;
      halt_o        <= 1'b0;
      instr_err_o   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.imem_rvalid) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == 4'd0) begin
              icode_o <= rdata[7:4];
              ifun_o  <= rdata[3:0];
              valC_o  <= '0;
              valP_o  <= pc_o + {60'b0, len};
              if (!has_reg(rdata[7:4])) begin
                rA_o <= 4'hF;
                rB_o <= 4'hF;
              end
            end else if (byte_idx == 4'd1 && has_reg(icode_o)) begin
              rA_o <= rdata[7:4];
              rB_o <= rdata[3:0];
            end else begin
              // Shift in from the top: after 8 bytes the first one sits in [7:0].
              valC_o <= {rdata, valC_o[63:8]};
            end

            if (byte_idx == 4'd0 && rdata[7:4] > 4'hB) begin
              state       <= S_ERR;
              instr_err_o <= 1'b1;
            end else if (last) begin
              instr_valid_o <= 1'b1;
              if (cur_icode == I_HALT) begin
                state  <= S_HALT;
                halt_o <= 1'b1;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (pc_next_valid_i) begin
            pc_o          <= pc_next_i;
            byte_idx      <= '0;
            valC_o        <= '0;
            instr_valid_o <= 1'b0;
            state         <= S_REQ;
          end
        end
        S_HALT: instr_valid_o <= 1'b0;
        S_ERR:  instr_valid_o <= 1'b0;
        default: state <= S_ERR;
      endcase
    end
  end

endmodule
